// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default bit timing.
// Also used by the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY_BIT = 3'd3,
        ST_STOP       = 3'd4
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // 50 MHz clock, 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    function automatic logic parity_of(input logic [7:0] data, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last count.
// Restart holds the count at zero so each frame begins on a fresh period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (reset || i_restart) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    assign o_tick = i_enable && !i_restart && w_last;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// All outputs are registered; tx_done pulses on the cycle after the last stop cycle.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned PARITY       = PARITY_NONE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] S_IDLE       = ST_IDLE;
    localparam logic [2:0] S_START      = ST_START;
    localparam logic [2:0] S_DATA       = ST_DATA;
    localparam logic [2:0] S_PARITY_BIT = ST_PARITY_BIT;
    localparam logic [2:0] S_STOP       = ST_STOP;

    logic [2:0] r_state;
    logic [7:0] r_shift;
    logic [2:0] r_index;
    logic       r_parity;
    logic       r_serial;
    logic       r_busy;
    logic       r_done;

    logic       w_idle;
    logic       w_tick;

    assign w_idle = (r_state == S_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (!w_idle),
        .i_restart (w_idle),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_index  <= '0;
            r_parity <= 1'b0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_shift  <= tx_data;
                        r_index  <= '0;
                        r_state  <= S_START;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        // Parity is taken here while the latched byte is still unshifted
                        r_parity <= parity_of(r_shift, PARITY);
                        r_serial <= r_shift[0];
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_index == 3'd7) begin
                            if (PARITY != PARITY_NONE) begin
                                r_state  <= S_PARITY_BIT;
                                r_serial <= r_parity;
                            end else begin
                                r_state  <= S_STOP;
                                r_serial <= 1'b1;
                            end
                        end else begin
                            r_index  <= r_index + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_serial <= r_shift[1];
                        end
                    end
                end
                S_PARITY_BIT: begin
                    if (w_tick) begin
                        r_state  <= S_STOP;
                        r_serial <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_state  <= S_IDLE;
                        r_serial <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_serial = r_serial;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: three instances (no/even/odd parity) at 4 clocks per bit.
// Outputs are sampled 1 ns after each rising edge.
module tb_uart_tx_engine;

    logic       clk;
    logic       reset;
    logic [2:0] start;
    logic [7:0] data [3];
    logic [2:0] ser;
    logic [2:0] busy;
    logic [2:0] done;

    int checks;
    int failures;

    uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY(0)) u_none (
        .clk(clk), .reset(reset), .tx_start(start[0]), .tx_data(data[0]),
        .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY(1)) u_even (
        .clk(clk), .reset(reset), .tx_start(start[1]), .tx_data(data[1]),
        .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY(2)) u_odd (
        .clk(clk), .reset(reset), .tx_start(start[2]), .tx_data(data[2]),
        .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int sel);
        check({tag, "_serial"}, 32'(ser[sel]), 32'd1);
        check({tag, "_busy"}, 32'(busy[sel]), 32'd0);
        check({tag, "_done"}, 32'(done[sel]), 32'd0);
    endtask

    // Requests a frame, checks every bit cycle, and returns in the tx_done cycle.
    task automatic frame(input int sel, input logic [7:0] d, input int pmode,
                         input bit pulse_start, input bit toggle_data);
        logic [10:0] bits;
        logic [7:0]  decoded;
        int          nbits;
        bits    = '1;
        decoded = '0;
        nbits   = (pmode == 0) ? 10 : 11;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pmode == 1) bits[9] = ^d;
        if (pmode == 2) bits[9] = ~(^d);

        start[sel] = 1'b1;
        data[sel]  = d;
        step();
        start[sel] = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("u%0d_d%02h_bit%0d_c%0d_serial", sel, d, b, c), 32'(ser[sel]), 32'(bits[b]));
                check($sformatf("u%0d_d%02h_bit%0d_c%0d_busy", sel, d, b, c), 32'(busy[sel]), 32'd1);
                check($sformatf("u%0d_d%02h_bit%0d_c%0d_done", sel, d, b, c), 32'(done[sel]), 32'd0);
                if (c == 1 && b >= 1 && b <= 8) decoded[b-1] = ser[sel];
                if (pulse_start) start[sel] = (((b * 4 + c) % 3) == 2) && !(b == nbits - 1 && c == 3);
                if (toggle_data) data[sel] = ~data[sel];
                step();
            end
        end
        start[sel] = 1'b0;
        check($sformatf("u%0d_d%02h_decoded", sel, d), 32'(decoded), 32'(d));
        check($sformatf("u%0d_d%02h_done_pulse", sel, d), 32'(done[sel]), 32'd1);
        check($sformatf("u%0d_d%02h_end_busy", sel, d), 32'(busy[sel]), 32'd0);
        check($sformatf("u%0d_d%02h_end_serial", sel, d), 32'(ser[sel]), 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = '0;
        for (int i = 0; i < 3; i++) data[i] = '0;

        repeat (3) step();
        for (int i = 0; i < 3; i++) check_idle($sformatf("reset_u%0d", i), i);
        reset = 1'b0;
        step();

        // 8'hA5 without parity: tx_done lands 41 cycles after the accepting cycle
        frame(0, 8'hA5, 0, 1'b0, 1'b0);
        step();
        check_idle("a5_after_done", 0);

        // 8'h07: even parity bit 1, odd parity bit 0, 44-cycle frames
        frame(1, 8'h07, 1, 1'b0, 1'b0);
        step();
        check_idle("even_after_done", 1);
        frame(2, 8'h07, 2, 1'b0, 1'b0);
        step();
        check_idle("odd_after_done", 2);

        // Repeated requests while busy must be dropped entirely
        frame(0, 8'h3C, 0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            check_idle($sformatf("ignored_start_idle%0d", i), 0);
        end

        // Back-to-back: second request issued in the tx_done cycle
        frame(0, 8'h00, 0, 1'b0, 1'b0);
        frame(0, 8'hFF, 0, 1'b0, 1'b0);
        step();
        check_idle("b2b_after_done", 0);

        // Reset during data bit 3 of 8'h55 (cycles 17..20 after acceptance)
        data[0]  = 8'h55;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (17) step();
        check("abort_bit3_serial", 32'(ser[0]), 32'd0);
        check("abort_bit3_busy", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("abort_next_cycle", 0);
        for (int i = 0; i < 45; i++) begin
            step();
            check_idle($sformatf("abort_quiet%0d", i), 0);
        end
        frame(0, 8'h55, 0, 1'b0, 1'b0);
        step();

        // Reset wins over a simultaneous request
        reset    = 1'b1;
        start[0] = 1'b1;
        data[0]  = 8'hAA;
        step();
        reset    = 1'b0;
        start[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("reset_priority%0d", i), 0);
        end

        // Live tx_data toggles every cycle after acceptance
        frame(0, 8'h81, 0, 1'b0, 1'b1);
        step();
        check_idle("toggle_after_done", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have parameter PARITY, default 0, with 0 = none, 1 = even, 2 = odd.
REQ-003 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous, active-high, on clock clk.
REQ-005 The block SHALL have port tx_start, input, 1 bit, a one-cycle request to send tx_data.
REQ-006 The block SHALL have port tx_data, input, 8 bits, the byte to send, sampled only on the accepting cycle.
REQ-007 The block SHALL have port tx_serial, output, 1 bit, the registered serial line, idle high.
REQ-008 The block SHALL have port tx_busy, output, 1 bit, high from the cycle after acceptance until frame end.
REQ-009 The block SHALL have port tx_done, output, 1 bit, a one-cycle pulse at frame completion.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, PARITY_BIT and STOP, all with registered outputs.
REQ-011 In IDLE, tx_start=1 SHALL latch tx_data into a shift register and move the FSM to START on the next edge.
REQ-012 tx_serial SHALL go low on the first cycle after acceptance, which is latency 1.
REQ-013 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that runs 0..CLKS_PER_BIT-1 and reloads to 0.
REQ-014 The frame SHALL be: start bit (0), data[0]..data[7] LSB first, then the parity bit if PARITY != 0, then one stop bit (1).
REQ-015 Even parity SHALL be the XOR of the latched byte; odd parity SHALL be its inverse; parity SHALL be computed from the latched copy, never from live tx_data.
REQ-016 A 3-bit bit index SHALL count 0..7 in DATA; leaving DATA at index 7 SHALL go to PARITY_BIT when PARITY != 0, otherwise to STOP.
REQ-017 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), measured from the first low cycle to the last stop cycle.
REQ-018 On the cycle after the last stop cycle: FSM = IDLE, tx_done = 1 for exactly one cycle, tx_busy = 0, tx_serial = 1.
REQ-019 tx_start asserted in that tx_done cycle SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-020 tx_start while tx_busy = 1 SHALL be ignored, with no queueing, no corruption of the current frame and no later effect.
REQ-021 Changes on tx_data after acceptance SHALL NOT affect the frame in flight.
REQ-022 tx_start held high continuously SHALL produce one frame per acceptance opportunity; the upstream sequencer pulses it once per byte.
REQ-023 tx_done SHALL never assert without a completed stop bit.

Reset
REQ-024 Reset SHALL set: tx_serial = 1, tx_busy = 0, tx_done = 0, FSM = IDLE, bit counter = 0, bit index = 0, shift register = 0.
REQ-025 Reset mid-frame SHALL abort the frame: line high on the next cycle and no tx_done pulse.
REQ-026 Reset SHALL take priority over a simultaneous tx_start; that request SHALL be dropped.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state enum, the PARITY encodings (NONE/EVEN/ODD) and the default CLKS_PER_BIT constant, for reuse by the matching receiver.
REQ-028 One sub-module, uart_baud_tick, SHALL provide the bit-period counter (inputs: enable, restart; output: a one-cycle tick at count CLKS_PER_BIT-1).
REQ-029 The bit-counter width SHALL be $clog2(CLKS_PER_BIT); the counter SHALL not overflow at any legal parameter value.

Verification
REQ-030 The bench SHALL cover, with CLKS_PER_BIT=4 and PARITY=0, tx_start pulse with tx_data=8'hA5 -> line low 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles; tx_done one cycle exactly 41 cycles after acceptance.
REQ-031 The bench SHALL cover PARITY=1 with 8'h07, and PARITY=2 with 8'h07 -> parity bit 1 (even) and 0 (odd); frame of 44 cycles.
REQ-032 The bench SHALL cover tx_start pulsed every 3 cycles during a frame of 8'h3C -> exactly one frame is sent, bits match 8'h3C, one tx_done.
REQ-033 The bench SHALL cover tx_start in the tx_done cycle with 8'h00 then 8'hFF -> the second start bit begins on the next cycle, with no idle gap.
REQ-034 The bench SHALL cover reset during the DATA bit 3 of 8'h55 -> tx_serial = 1 and tx_busy = 0 on the next cycle; no tx_done; the next request sends a clean frame.
REQ-035 The bench SHALL cover tx_data toggling every cycle after accepting 8'h81 -> the serial output still decodes to 8'h81.
